// File: rtl/fft_pkg.sv
// fft_pkg: shared FSM encoding and default sizes for one radix-2 DIF FFT stage
package fft_pkg;
  localparam int N_DEF = 128;
  localparam int LOGN_DEF = 7;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;
endpackage

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: LAT-deep valid/payload delay line sharing one advance enable
// Ports: clk, rst (async, active low), adv shifts all stages, in_v/in_d enter stage 0,
//        out_v/out_d leave the last stage, any_v = some stage holds a word.
module ctrl_pipe #(
  parameter int LAT = 2,
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv,
  input  logic         in_v,
  input  logic [W-1:0] in_d,
  output logic         out_v,
  output logic [W-1:0] out_d,
  output logic         any_v
);
  logic [LAT-1:0] v_q;
  logic [W-1:0]   d_q [LAT];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q <= '0;
      for (int i = 0; i < LAT; i++) d_q[i] <= '0;
    end else if (adv) begin
      v_q[0] <= in_v;
      d_q[0] <= in_d;
      for (int i = 1; i < LAT; i++) begin
        v_q[i] <= v_q[i-1];
        d_q[i] <= d_q[i-1];
      end
    end
  end
  assign out_v = v_q[LAT-1];
  assign out_d = d_q[LAT-1];
  assign any_v = |v_q;
endmodule

// File: rtl/twiddle_sched_ctrl.sv
// twiddle_sched_ctrl: per-sample twiddle address/bypass sequencer for one DIF FFT stage
// Ports: clk, rst (async, active low), en allows new frames, cfg_stage sampled at frame start,
//        in_valid/in_ready upstream handshake, out_valid/out_ready downstream handshake,
//        tw_addr/tw_bypass/out_sof/out_eof aligned control word, busy, err_stage (sticky).
module twiddle_sched_ctrl
  import fft_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int LOGN = LOGN_DEF,
  parameter int SW = 3,
  parameter int LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [SW-1:0]   cfg_stage,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LOGN-2:0] tw_addr,
  output logic            tw_bypass,
  output logic            out_sof,
  output logic            out_eof,
  output logic            busy,
  output logic            err_stage
);
  state_e          state_q, state_d;
  logic [LOGN-1:0] cnt_q, cnt_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic            err_q, err_d;
  logic            adv, acc, last, bad, pipe_any, hi;
  logic [SW-1:0]   s_cfg, s;
  logic [LOGN-1:0] mask, half, p, diff;
  logic [LOGN-2:0] k, addr;
  logic [LOGN+1:0] pd;
  assign adv = ~out_valid | out_ready;
  // in_ready is gated by rst so it drops the moment reset asserts
  assign in_ready = rst & adv & (state_q == RUN | (state_q == IDLE & en));
  assign acc = in_valid & in_ready;
  assign last = state_q == RUN & cnt_q == LOGN'(N - 1);
  assign bad = int'(cfg_stage) >= LOGN;
  assign s_cfg = bad ? SW'(LOGN - 1) : cfg_stage;
  assign s = state_q == IDLE ? s_cfg : stage_q;
  assign mask = LOGN'((N >> s) - 1);
  assign half = LOGN'((N >> s) >> 1);
  assign p = cnt_q & mask;
  assign hi = p >= half;
  assign diff = p - half;
  assign k = (LOGN-1)'(diff << s);
  assign addr = hi ? k : '0;
  assign busy = state_q != IDLE | pipe_any;
  assign err_stage = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    stage_d = stage_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (acc) begin
        state_d = RUN;
        cnt_d = LOGN'(1);
        stage_d = s_cfg;
        err_d = err_q | bad;
      end
      RUN: if (acc) begin
        cnt_d = cnt_q + LOGN'(1);
        state_d = last ? DRAIN : RUN;
      end
      DRAIN: state_d = pipe_any ? DRAIN : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      stage_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      stage_q <= stage_d;
      err_q <= err_d;
    end
  end
  ctrl_pipe #(.LAT(LAT), .W(LOGN + 2)) u_pipe (
    .clk  (clk),
    .rst  (rst),
    .adv  (adv),
    .in_v (acc),
    .in_d ({addr, ~hi | k == '0, state_q == IDLE, last}),
    .out_v(out_valid),
    .out_d(pd),
    .any_v(pipe_any)
  );
  assign {tw_addr, tw_bypass, out_sof, out_eof} = pd;
endmodule

// File: tb/tb_twiddle_sched_ctrl.sv
// tb_twiddle_sched_ctrl: directed self-checking bench for twiddle_sched_ctrl
module tb_twiddle_sched_ctrl;
  localparam int N = 128;
  localparam int LAT = 2;
  logic clk = 0, rst = 0, en = 1, in_valid = 0, out_ready = 1;
  logic [2:0] cfg_stage = '0;
  logic in_ready, out_valid, tw_bypass, out_sof, out_eof, busy, err_stage;
  logic [5:0] tw_addr;
  logic [8:0] got [N];
  int checks = 0, errors = 0, gcyc = 0, last_acc = -1;
  twiddle_sched_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .cfg_stage(cfg_stage), .in_valid(in_valid),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .tw_addr(tw_addr),
    .tw_bypass(tw_bypass), .out_sof(out_sof), .out_eof(out_eof), .busy(busy), .err_stage(err_stage)
  );
  always #5 clk = ~clk;
  always @(posedge clk) gcyc <= gcyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [8:0] model(input int s, input int p);
    int b, j, k;
    b = N >> s;
    j = p % b;
    k = j < b / 2 ? 0 : ((j - b / 2) << s) % 64;
    return {6'(k), j < b / 2 || k == 0, p == 0, p == N - 1};
  endfunction
  task automatic frame(input int cfg, input int s, input int bp_at, input int bp_len);
    int acc_n, w, cyc, fa, fo;
    logic [8:0] held, word;
    bit hold;
    acc_n = 0; w = 0; cyc = 0; fa = -1; fo = -1; hold = 0; held = '0;
    cfg_stage = 3'(cfg);
    while (w < N && cyc < 3000) begin
      @(negedge clk);
      out_ready = !(cyc >= bp_at && cyc < bp_at + bp_len);
      in_valid = acc_n < N;
      if (acc_n > 0) cfg_stage = 3'((cfg + 3) % 7);
      #1;
      word = {tw_addr, tw_bypass, out_sof, out_eof};
      if (hold) chk("hold", {out_valid, word}, {1'b1, held});
      if (out_valid && !out_ready) chk("bp_in_ready", in_ready, 0);
      if (acc_n == N) chk("drain_in_ready", in_ready, 0);
      if (acc_n > 0) chk("busy", busy, 1);
      if (in_valid && in_ready) begin
        if (fa < 0) begin
          fa = cyc;
          if (last_acc >= 0) chk("drain_gap", 32'(gcyc - last_acc > LAT), 1);
        end
        acc_n++;
        last_acc = gcyc;
      end
      hold = out_valid && !out_ready;
      held = word;
      if (out_valid && out_ready) begin
        if (fo < 0) fo = cyc;
        got[w] = word;
        chk("word", word, model(s, w));
        w++;
      end
      cyc++;
    end
    in_valid = 0;
    out_ready = 1;
    chk("word_count", w, N);
    chk("acc_count", acc_n, N);
    if (bp_len == 0) chk("latency", fo - fa, LAT);
  endtask
  initial begin
    in_valid = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_stage, 0);
    rst = 1;
    in_valid = 0;
    frame(0, 0, 0, 0);
    chk("s0_w0", got[0], 9'h006);
    chk("s0_w63", got[63], 9'h004);
    chk("s0_w64", got[64], 9'h004);
    chk("s0_w65", got[65], 9'h008);
    chk("s0_w127", got[127], 9'h1F9);
    frame(5, 5, 0, 0);
    chk("s5_w2", got[2], 9'h004);
    chk("s5_w3", got[3], 9'h100);
    chk("s5_w127", got[127], 9'h101);
    frame(0, 0, 20, 5);
    frame(1, 1, 0, 0);
    chk("s1_w33", got[33], 9'h010);
    frame(2, 2, 0, 0);
    chk("s2_w17", got[17], 9'h020);
    chk("err_clear", err_stage, 0);
    frame(7, 6, 0, 0);
    chk("s7_w1", got[1], 9'h004);
    chk("err_set", err_stage, 1);
    repeat (4) @(negedge clk);
    #1;
    chk("idle_busy", busy, 0);
    cfg_stage = 3'd0;
    in_valid = 1;
    repeat (42) @(negedge clk);
    rst = 0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err", err_stage, 0);
    chk("arst_word", {tw_addr, tw_bypass, out_sof, out_eof}, 0);
    @(negedge clk);
    rst = 1;
    in_valid = 0;
    last_acc = -1;
    frame(3, 3, 0, 0);
    chk("s3_w0", got[0], 9'h006);
    en = 0;
    in_valid = 1;
    repeat (6) @(negedge clk);
    #1;
    chk("en0_in_ready", in_ready, 0);
    chk("en0_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
